fetch_sequencer: RTL and testbench

- Control FSM that sequences instruction fetch into the instruction register.
- Drives the PC onto the address bus, issues a memory read, and waits for memory ready.
- Pulses the instruction register's active-low load, increments the PC, and optionally fetches a second immediate word.
- Hands control to the execute stage and waits for it to finish. Sits between PC, memory interface, instruction register and execute control.

---
 rtl/fetch_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Control FSM that sequences an instruction fetch into the
//            instruction register. It puts the PC on the address bus, strobes
//            a memory read and waits for memory ready. It then pulses the IR
//            load and increments the PC. If the decoder asks for one, it
//            fetches a second (immediate) word the same way. Finally it hands
//            the datapath to the execute stage until that stage finishes.
// Ports    : clock       - system clock, rising edge
//            notReset    - synchronous active-low reset
//            memReady    - memory read data valid (held while notMemRead low)
//            needImm     - opcode in IR carries an immediate word
//            execDone    - execute stage finished (sampled in EXEC only)
//            haltReq     - halt request (sampled when EXEC completes only)
//            notPcOE     - active-low PC output enable onto address bus
//            notMemRead  - active-low memory read strobe
//            notIrLoad   - active-low instruction register load
//            notImmLoad  - active-low immediate register load
//            pcInc       - PC increment pulse
//            execActive  - execute stage owns the datapath
//            halted      - FSM parked in HALT
//            fault       - FSM parked in FAULT (memory timeout)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int MEM_TIMEOUT = 15,  // max WAIT cycles before fault, 0 = never
    parameter int CNT_WIDTH   = 4    // wait counter width, must hold MEM_TIMEOUT
) (
    input  logic clock,
    input  logic notReset,
    input  logic memReady,
    input  logic needImm,
    input  logic execDone,
    input  logic haltReq,
    output logic notPcOE,
    output logic notMemRead,
    output logic notIrLoad,
    output logic notImmLoad,
    output logic pcInc,
    output logic execActive,
    output logic halted,
    output logic fault
);

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_WAIT   = 4'd2,
        ST_LOAD   = 4'd3,
        ST_DECODE = 4'd4,
        ST_IFETCH = 4'd5,
        ST_IWAIT  = 4'd6,
        ST_ILOAD  = 4'd7,
        ST_EXEC   = 4'd8,
        ST_HALT   = 4'd9,
        ST_FAULT  = 4'd10
    } state_t;

    // Last counter value allowed in a wait state. The counter is zero on
    // entry, so reaching C_LIMIT means MEM_TIMEOUT wait cycles have elapsed.
    localparam logic [CNT_WIDTH-1:0] C_LIMIT =
        (MEM_TIMEOUT == 0) ? '0 : CNT_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic C_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic notPcOE_q,    notPcOE_d;
    logic notMemRead_q, notMemRead_d;
    logic notIrLoad_q,  notIrLoad_d;
    logic notImmLoad_q, notImmLoad_d;
    logic pcInc_q,      pcInc_d;
    logic execActive_q, execActive_d;
    logic halted_q,     halted_d;
    logic fault_q,      fault_d;

    logic timeout_w;

    assign timeout_w = C_TIMEOUT_EN && (cnt_q == C_LIMIT);

    // ------------------------------------------------------------------------
    // Next-state and wait-counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // memReady has priority over an expiring timeout.
                if (memReady) begin
                    state_d = ST_LOAD;
                end else if (timeout_w) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // The IR captured the opcode on the LOAD edge, so the
                // decoder flag is meaningful here for the first time.
                state_d = needImm ? ST_IFETCH : ST_EXEC;
            end
            ST_IFETCH: begin
                cnt_d   = '0;
                state_d = ST_IWAIT;
            end
            ST_IWAIT: begin
                if (memReady) begin
                    state_d = ST_ILOAD;
                end else if (timeout_w) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ILOAD: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // haltReq only matters once the current instruction retires;
                // the PC already points past it so no further fetch occurs.
                if (execDone) begin
                    state_d = haltReq ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unused encodings recover through RST.
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode of the next state. The outputs are registered from this
    // decode, so each output is a pure function of state_q. No input reaches
    // an output combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        notPcOE_d    = 1'b1;
        notMemRead_d = 1'b1;
        notIrLoad_d  = 1'b1;
        notImmLoad_d = 1'b1;
        pcInc_d      = 1'b0;
        execActive_d = 1'b0;
        halted_d     = 1'b0;
        fault_d      = 1'b0;
        case (state_d)
            ST_FETCH, ST_WAIT, ST_IFETCH, ST_IWAIT: begin
                notPcOE_d    = 1'b0;
                notMemRead_d = 1'b0;
            end
            ST_LOAD: begin
                notPcOE_d    = 1'b0;
                notMemRead_d = 1'b0;
                notIrLoad_d  = 1'b0;
                pcInc_d      = 1'b1;
            end
            ST_ILOAD: begin
                notPcOE_d    = 1'b0;
                notMemRead_d = 1'b0;
                notImmLoad_d = 1'b0;
                pcInc_d      = 1'b1;
            end
            ST_EXEC: begin
                execActive_d = 1'b1;
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                // RST, DECODE and unused encodings: everything inactive.
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!notReset) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            notPcOE_q    <= 1'b1;
            notMemRead_q <= 1'b1;
            notIrLoad_q  <= 1'b1;
            notImmLoad_q <= 1'b1;
            pcInc_q      <= 1'b0;
            execActive_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            notPcOE_q    <= notPcOE_d;
            notMemRead_q <= notMemRead_d;
            notIrLoad_q  <= notIrLoad_d;
            notImmLoad_q <= notImmLoad_d;
            pcInc_q      <= pcInc_d;
            execActive_q <= execActive_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign notPcOE    = notPcOE_q;
    assign notMemRead = notMemRead_q;
    assign notIrLoad  = notIrLoad_q;
    assign notImmLoad = notImmLoad_q;
    assign pcInc      = pcInc_q;
    assign execActive = execActive_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed bench for fetch_sequencer. The stimulus process pushes
//            the hand-derived output vector expected after each clock edge.
//            It also pushes an optional expectation for a second instance
//            built with the timeout disabled. A monitor pops the queue on
//            every falling edge and compares.
//            Vector order: {notPcOE, notMemRead, notIrLoad, notImmLoad,
//                           pcInc, execActive, halted, fault}
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [7:0] O_RST = 8'b1111_0000;
    localparam logic [7:0] O_FW  = 8'b0011_0000;  // FETCH/WAIT/IFETCH/IWAIT
    localparam logic [7:0] O_LD  = 8'b0001_1000;
    localparam logic [7:0] O_IL  = 8'b0010_1000;
    localparam logic [7:0] O_DEC = 8'b1111_0000;
    localparam logic [7:0] O_EX  = 8'b1111_0100;
    localparam logic [7:0] O_HLT = 8'b1111_0010;
    localparam logic [7:0] O_FLT = 8'b1111_0001;

    typedef struct {
        string      nm;
        logic [7:0] exp;
        logic       chkb;
        logic [7:0] expb;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    logic clk = 1'b0;
    logic notReset, memReady, needImm, execDone, haltReq;
    logic a_pcoe, a_mrd, a_irl, a_iml, a_inc, a_ex, a_hlt, a_flt;
    logic b_pcoe, b_mrd, b_irl, b_iml, b_inc, b_ex, b_hlt, b_flt;

    int n_vec = 0;
    int n_bad = 0;
    logic       g_chkb = 1'b0;
    logic [7:0] g_expb = 8'h00;

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_TIMEOUT(15), .CNT_WIDTH(4)) u_dut (
        .clock(clk), .notReset(notReset), .memReady(memReady),
        .needImm(needImm), .execDone(execDone), .haltReq(haltReq),
        .notPcOE(a_pcoe), .notMemRead(a_mrd), .notIrLoad(a_irl),
        .notImmLoad(a_iml), .pcInc(a_inc), .execActive(a_ex),
        .halted(a_hlt), .fault(a_flt)
    );

    fetch_sequencer #(.MEM_TIMEOUT(0), .CNT_WIDTH(4)) u_dut_nto (
        .clock(clk), .notReset(notReset), .memReady(1'b0),
        .needImm(needImm), .execDone(execDone), .haltReq(haltReq),
        .notPcOE(b_pcoe), .notMemRead(b_mrd), .notIrLoad(b_irl),
        .notImmLoad(b_iml), .pcInc(b_inc), .execActive(b_ex),
        .halted(b_hlt), .fault(b_flt)
    );

    wire [7:0] outs_a = {a_pcoe, a_mrd, a_irl, a_iml, a_inc, a_ex, a_hlt, a_flt};
    wire [7:0] outs_b = {b_pcoe, b_mrd, b_irl, b_iml, b_inc, b_ex, b_hlt, b_flt};

    // Just after an edge: record what the outputs must be now, then drive the
    // inputs that the following edge will sample.
    task automatic cyc(input string nm, input logic [7:0] exp,
                       input logic rn, input logic mr, input logic ni,
                       input logic ed, input logic hr);
        sb_t item;
        @(posedge clk);
        #1;
        item.nm   = nm;
        item.exp  = exp;
        item.chkb = g_chkb;
        item.expb = g_expb;
        sb.push_back(item);
        notReset = rn;
        memReady = mr;
        needImm  = ni;
        execDone = ed;
        haltReq  = hr;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec = n_vec + 1;
            if (outs_a !== e.exp) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: outputs %b, expected %b (t=%0t)", e.nm, outs_a, e.exp, $time);
            end
            if (e.chkb) begin
                n_vec = n_vec + 1;
                if (outs_b !== e.expb) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s_nto: outputs %b, expected %b (t=%0t)", e.nm, outs_b, e.expb, $time);
                end
            end
        end
    end

    initial begin
        notReset = 1'b0;
        memReady = 1'b0;
        needImm  = 1'b0;
        execDone = 1'b0;
        haltReq  = 1'b0;

        // Reset held three edges, then free-running fetch loop.
        cyc("rst", O_RST, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rst", O_RST, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rst", O_RST, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc("fetch",  O_FW,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("wait",   O_FW,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("load",   O_LD,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("decode", O_DEC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("exec",   O_EX,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Slow memory: five WAIT cycles, ready on the fifth.
        cyc("fetch_slow", O_FW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            cyc("wait_slow", O_FW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("wait_slow",  O_FW,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("load_slow",  O_LD,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("dec_slow",   O_DEC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("exec_slow",  O_EX,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Immediate fetch, haltReq raised early (ignored), long execute, halt.
        cyc("fetch_imm",  O_FW,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("wait_imm",   O_FW,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("load_imm",   O_LD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("dec_imm",    O_DEC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("ifetch",     O_FW,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("iwait",      O_FW,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("iload",      O_IL,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++)
            cyc("exec_busy", O_EX, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("exec_halt",  O_EX,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            cyc("halt", O_HLT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("halt", O_HLT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Memory never ready: fault 16 cycles after FETCH, sticky until reset.
        cyc("rst_to",   O_RST, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("fetch_to", O_FW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++)
            cyc("wait_to", O_FW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("fault", O_FLT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("fault", O_FLT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("fault", O_FLT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst_after_fault", O_RST, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // memReady arrives on the very cycle the timeout would fire.
        cyc("fetch_lim", O_FW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++)
            cyc("wait_lim", O_FW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wait_lim", O_FW,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("load_lim", O_LD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset asserted while stalled in IWAIT: straight to RST, no strobes.
        cyc("dec_lim",   O_DEC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ifetch_rs", O_FW,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc("iwait_rs", O_FW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("iwait_rs", O_FW,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst_iwait", O_RST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout disabled instance: stays in WAIT through 100+ idle cycles,
        // while the MEM_TIMEOUT=15 instance faults alongside it.
        g_chkb = 1'b1;
        g_expb = O_RST;
        cyc("rst_nto", O_RST, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        g_expb = O_FW;
        for (int k = 0; k < 102; k++)
            cyc("idle_nto", (k <= 15) ? O_FW : O_FLT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        g_chkb = 1'b0;

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
